bus_responder: RTL and testbench

Memory-mapped data-bus responder for the cpu32e2 SoC: the target end of the CPU's read/write transaction interface. It accepts single-word reads and writes with byte enables and holds `waitRequest` high only during post-reset memory initialisation. Accepted reads are pipelined: each read returns a one-cycle `readValid` pulse with data a fixed number of cycles after acceptance, in order and at full throughput. Backing store is an internal word-addressed synchronous RAM.

---
 rtl/bus_responder_pkg.sv | 25 ++
 rtl/bus_responder_read_pipeline.sv | 34 +++
 rtl/bus_responder.sv | 145 ++++++++++++++
 tb/tb_bus_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus_responder memory target.
// Optional feature macro used by the top level: RESPONDER_BOUNDS_CHECK_EN.
package responderPkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } states;

  localparam logic [31:0] ERROR_READ_DATA  = 32'hDEAD_BEEF;
  localparam int          MAX_READ_LATENCY = 4;

  // Byte-lane merge used for partial writes into an existing word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (lane_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_responder_read_pipeline.sv
// Fixed-depth shift register of {valid, error} read tokens, cleared asynchronously.
// Stage DEPTH-1 is the token whose data is presented on the bus this cycle.
module readPipeline #(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_error_i,
  output logic [DEPTH-1:0] valid_o,
  output logic [DEPTH-1:0] error_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] error_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      error_q <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      error_q[0] <= in_valid_i & in_error_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        error_q[i] <= error_q[i-1];
      end
    end
  end

  assign valid_o = valid_q;
  assign error_o = error_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped read/write target with post-reset RAM zeroing and pipelined reads.
// Define RESPONDER_BOUNDS_CHECK_EN to reject addresses above the RAM window.
module bus_responder
  import responderPkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [3:0]  byteEnable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writeData,
  output logic        waitRequest,
  output logic        readValid,
  output logic [31:0] readData,
  output logic        responseError,
  output states       state_o
);

  // Handshake: a request is taken on a rising edge where (read | write) is high
  // and waitRequest is low; write wins when both are set. readValid is a
  // one-cycle pulse per accepted read, with no back-pressure on the return.

  localparam int                    WORDS     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_WORD  = ADDR_WIDTH'(1);

  states                 state_q;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic                  wait_q;
  logic [31:0]           mem [WORDS];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  oob;
  logic [31:0]           wr_word_d;

  assign word_idx = address[ADDR_WIDTH+1:2];

`ifdef RESPONDER_BOUNDS_CHECK_EN
  assign oob = |address[31:ADDR_WIDTH+2];
`else
  // Upper address bits alias onto the RAM window.
  assign oob = 1'b0;
  logic unused_upper_addr;
  assign unused_upper_addr = ^address[31:ADDR_WIDTH+2];
`endif

  logic unused_low_addr;
  assign unused_low_addr = ^address[1:0];

  assign req_acc = (read | write) & ~wait_q;
  assign wr_acc  = req_acc & write;
  assign rd_acc  = req_acc & read & ~write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      wait_q  <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + ONE_WORD;
          if (sweep_q == LAST_WORD) begin
            state_q <= READY;
            wait_q  <= 1'b0;
          end
        end
        READY: begin
          wait_q <= 1'b0;
        end
        default: begin
          state_q <= INIT;
          wait_q  <= 1'b1;
        end
      endcase
    end
  end

  assign wr_word_d = merge_lanes(mem[word_idx], writeData, byteEnable);

  // RAM has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[sweep_q] <= '0;
    end else if (wr_acc && !oob) begin
      mem[word_idx] <= wr_word_d;
    end
  end

  logic [READ_LATENCY-1:0] tok_valid;
  logic [READ_LATENCY-1:0] tok_err;
  logic                    tail_err;

  readPipeline #(
    .DEPTH(READ_LATENCY)
  ) u_read_pipeline (
    .clk_i     (clk),
    .rst_i     (reset),
    .in_valid_i(rd_acc),
    .in_error_i(oob),
    .valid_o   (tok_valid),
    .error_o   (tok_err)
  );

  // Error flag of the token that will be presented after the next edge.
  if (READ_LATENCY == 1) begin : g_tail_direct
    assign tail_err = rd_acc & oob;
  end else begin : g_tail_stage
    assign tail_err = tok_err[READ_LATENCY-2];
  end

  logic unused_last_err;
  assign unused_last_err = tok_err[READ_LATENCY-1];

  logic [31:0] dat_q [READ_LATENCY];
  logic        err_q;

  // Data moves with its token only, so the last stage holds between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      if (rd_acc) dat_q[0] <= oob ? ERROR_READ_DATA : mem[word_idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        if (tok_valid[i-1]) dat_q[i] <= dat_q[i-1];
      end
      err_q <= tail_err | (wr_acc & oob);
    end
  end

  assign waitRequest   = wait_q;
  assign readValid     = tok_valid[READ_LATENCY-1];
  assign readData      = dat_q[READ_LATENCY-1];
  assign responseError = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder against a word-array reference model.
module tb_bus_responder;

  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [3:0]  byteEnable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writeData = '0;
  logic        waitRequest;
  logic        readValid;
  logic [31:0] readData;
  logic        responseError;
  responderPkg::states dbg_state;

  always #5 clk = ~clk;

  bus_responder #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .byteEnable   (byteEnable),
    .read         (read),
    .write        (write),
    .writeData    (writeData),
    .waitRequest  (waitRequest),
    .readValid    (readValid),
    .readData     (readData),
    .responseError(responseError),
    .state_o      (dbg_state)
  );

  int          n_checks = 0;
  int          n_bad = 0;
  logic [31:0] mdl_mem [DEPTH];
  logic [32:0] exp_q[$];
  int          due_q[$];
  int          werr_q[$];
  int          edge_cnt = 0;
  int          init_cnt = 0;
  logic [31:0] last_data = '0;
  logic        e_wait, e_valid, e_err;
  logic [31:0] e_data;

  function automatic logic oob_f(input logic [31:0] a);
`ifdef RESPONDER_BOUNDS_CHECK_EN
    return |a[31:AW+2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    werr_q.delete();
    init_cnt  = 0;
    last_data = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
  endtask

  // Drives one cycle, updates the model and leaves the expected outputs in e_*.
  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd);
    logic acc;
    int   idx;
    read = rd; write = wr; address = addr; byteEnable = be; writeData = wd;
    acc = (init_cnt == DEPTH) && (rd || wr);
    idx = int'(addr[AW+1:2]);
    if (acc && wr) begin
      if (oob_f(addr)) werr_q.push_back(edge_cnt + 1);
      else for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end else if (acc && rd) begin
      exp_q.push_back(oob_f(addr) ? {1'b1, 32'hDEAD_BEEF} : {1'b0, mdl_mem[idx]});
      due_q.push_back(edge_cnt + LAT);
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    if (init_cnt < DEPTH) init_cnt++;
    e_wait  = (init_cnt != DEPTH);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
      e_valid = 1'b1;
      {e_err, last_data} = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    e_data = last_data;
    if (werr_q.size() > 0 && werr_q[0] == edge_cnt) begin
      e_err = 1'b1;
      void'(werr_q.pop_front());
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    #2;
    n_checks++;
    if ({waitRequest, readValid, readData, responseError} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values got w/v/d/e=%b/%b/%h/%b want 1/0/00000000/0",
               waitRequest, readValid, readData, responseError);
    end
    n_checks++;
    if (dbg_state !== responderPkg::INIT) begin
      n_bad++;
      $display("FAIL reset_state got %0d want %0d", dbg_state, responderPkg::INIT);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 1;
    while (waitRequest && cnt < 100) begin
      step(1'b0, 1'b0, '0, '0, '0);
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL init_sweep edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (waitRequest) cnt++;
    end
    n_checks++;
    if (cnt != 16) begin
      n_bad++;
      $display("FAIL init_length got %0d cycles want 16", cnt);
    end
  endtask

  task automatic test_first_read();
    int seen_at;
    seen_at = -1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) step(1'b1, 1'b0, 32'h0, '0, '0);
      else step(1'b0, 1'b0, '0, '0, '0);
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL first_read edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (readValid && seen_at < 0) seen_at = k;
    end
    n_checks++;
    if (seen_at != 1) begin
      n_bad++;
      $display("FAIL first_read_latency got step %0d want step 1", seen_at);
    end
  endtask

  task automatic test_byte_enable();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: step(1'b0, 1'b1, 32'h8, 4'hF, 32'hAAAA_AAAA);
        1: step(1'b0, 1'b1, 32'h8, 4'b0101, 32'h1122_3344);
        2: step(1'b1, 1'b0, 32'h8, '0, '0);
        default: step(1'b0, 1'b0, '0, '0, '0);
      endcase
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL byte_enable edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (k == 3) begin
        n_checks++;
        if (readValid !== 1'b1 || readData !== 32'hAA22_AA44) begin
          n_bad++;
          $display("FAIL byte_enable_word got v=%b d=%h want v=1 d=aa22aa44", readValid, readData);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    int          pos[$];
    for (int k = 0; k < 12; k++) begin
      if (k < 4) step(1'b0, 1'b1, 32'(k * 4), 4'hF, 32'(k + 1));
      else if (k < 8) step(1'b1, 1'b0, 32'((k - 4) * 4), '0, '0);
      else step(1'b0, 1'b0, '0, '0, '0);
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL back_to_back edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (readValid) begin
        got.push_back(readData);
        pos.push_back(k);
      end
    end
    n_checks++;
    if (got.size() != 4) begin
      n_bad++;
      $display("FAIL back_to_back_count got %0d returns want 4", got.size());
    end else if (got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3 || got[3] !== 32'd4
                 || pos[3] - pos[0] != 3) begin
      n_bad++;
      $display("FAIL back_to_back_data got %h %h %h %h span %0d want 1 2 3 4 span 3",
               got[0], got[1], got[2], got[3], pos[3] - pos[0]);
    end
  endtask

  task automatic test_read_write_same();
    int valids;
    valids = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) step(1'b1, 1'b1, 32'h4, 4'hF, 32'h5);
      else if (k == 4) step(1'b1, 1'b0, 32'h4, '0, '0);
      else step(1'b0, 1'b0, '0, '0, '0);
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL rw_same edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (k < 4 && readValid) valids++;
      if (k == 5) begin
        n_checks++;
        if (readValid !== 1'b1 || readData !== 32'h5) begin
          n_bad++;
          $display("FAIL rw_same_readback got v=%b d=%h want v=1 d=00000005", readValid, readData);
        end
      end
    end
    n_checks++;
    if (valids != 0) begin
      n_bad++;
      $display("FAIL rw_same_no_return got %0d returns want 0", valids);
    end
  endtask

  task automatic test_reset_midflight();
    int valids;
    int waits;
    step(1'b1, 1'b0, 32'h8, '0, '0);
    step(1'b1, 1'b0, 32'hC, '0, '0);
    read = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({waitRequest, readValid, readData} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL midflight_async got w/v/d=%b/%b/%h want 1/0/00000000",
               waitRequest, readValid, readData);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    valids = 0;
    waits  = 1;
    for (int k = 0; k < DEPTH + 8; k++) begin
      if (k % 3 == 0) step(1'b0, 1'b1, 32'h8, 4'hF, 32'hFFFF_FFFF);
      else if (k >= DEPTH) step(1'b1, 1'b0, 32'(k * 4), '0, '0);
      else step(1'b1, 1'b0, 32'h8, '0, '0);
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL midflight edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (k < DEPTH && readValid) valids++;
      if (waitRequest) waits++;
    end
    n_checks++;
    if (valids != 0 || waits != DEPTH) begin
      n_bad++;
      $display("FAIL midflight_restart got returns=%0d wait_cycles=%0d want 0 and %0d",
               valids, waits, DEPTH);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] want;
`ifdef RESPONDER_BOUNDS_CHECK_EN
    want = 32'hDEAD_BEEF;
`else
    want = 32'h1234_5678;
`endif
    for (int k = 0; k < 10; k++) begin
      case (k)
        0: step(1'b0, 1'b1, 32'h0, 4'hF, 32'h1234_5678);
        1: step(1'b1, 1'b0, 32'h8000_0000, '0, '0);
        4: step(1'b0, 1'b1, 32'h4000_0004, 4'hF, 32'h77);
        5: step(1'b1, 1'b0, 32'h4, '0, '0);
        default: step(1'b0, 1'b0, '0, '0, '0);
      endcase
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL bounds edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
      if (k == 2) begin
        n_checks++;
        if (readValid !== 1'b1 || readData !== want) begin
          n_bad++;
          $display("FAIL bounds_high_read got v=%b d=%h want v=1 d=%h", readValid, readData, want);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 5);
      a  = 32'($urandom_range(0, DEPTH - 1)) << 2 | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[31:AW+2] = $urandom;
      case (op)
        0:       step(1'b0, 1'b0, a, 4'($urandom), $urandom);
        1, 2:    step(1'b1, 1'b0, a, 4'($urandom), $urandom);
        3, 4:    step(1'b0, 1'b1, a, 4'($urandom), $urandom);
        default: step(1'b1, 1'b1, a, 4'($urandom), $urandom);
      endcase
      n_checks++;
      if ({waitRequest, readValid, readData, responseError} !== {e_wait, e_valid, e_data, e_err}) begin
        n_bad++;
        $display("FAIL random edge=%0d got w/v/d/e=%b/%b/%h/%b want %b/%b/%h/%b", edge_cnt,
                 waitRequest, readValid, readData, responseError, e_wait, e_valid, e_data, e_err);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_read();
    test_byte_enable();
    test_back_to_back();
    test_read_write_same();
    test_reset_midflight();
    test_bounds();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
